radar_sweep_ctrl: RTL and testbench

- Sweeps the radar head servo back and forth between 0° and ANGLE_MAX.
- At each angle, commands one measurement from the ultrasonic rangefinder core (the avalon_telemetre trig/echo path) and consumes its 10-bit distance result.
- Buffers {angle, distance} samples in a show-ahead FIFO that the Nios II system reads over a simple pop interface.
- Sits directly downstream of the rangefinder's distance output and upstream of the Avalon readout.

---
 rtl/radar_sweep_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_radar_sweep_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/radar_sweep_ctrl.sv
// Radar head sweep controller: steps a servo between 0 and ANGLE_MAX, takes one
// rangefinder measurement per angle and queues {angle, distance} in a show-ahead FIFO.
module radar_sweep_ctrl #(
    parameter int unsigned PWM_PERIOD_CYC = 1000000,
    parameter int unsigned PULSE_MIN_CYC  = 50000,
    parameter int unsigned CYC_PER_DEG    = 278,
    parameter int unsigned ANGLE_MAX      = 180,
    parameter int unsigned STEP_DEG       = 2,
    parameter int unsigned SETTLE_PERIODS = 2,
    parameter int unsigned TIMEOUT_CYC    = 3000000,
    parameter int unsigned FIFO_DEPTH     = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    output logic                          meas_start,
    input  logic                          meas_done,
    input  logic [9:0]                    meas_dist,
    output logic                          pwm_out,
    input  logic                          rd_en,
    output logic [17:0]                   rd_data,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    input  logic                          clr_ovf,
    output logic [7:0]                    cur_angle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [31:0]   PERIOD_LAST  = 32'(PWM_PERIOD_CYC - 1);
    localparam logic [31:0]   PULSE_MIN    = 32'(PULSE_MIN_CYC);
    localparam logic [31:0]   DEG_CYC      = 32'(CYC_PER_DEG);
    localparam logic [7:0]    ANGLE_TOP    = 8'(ANGLE_MAX);
    localparam logic [8:0]    STEP9        = 9'(STEP_DEG);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_PERIODS - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] DEPTH_CNT    = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        STORE   = 3'd3,
        NEXT    = 3'd4
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Servo PWM
    // ------------------------------------------------------------------
    logic [31:0] pwm_cnt, pwm_cnt_next;
    logic [31:0] width_q, width_next, width_calc;
    logic        period_start;

    assign period_start = (pwm_cnt == 32'd0);

    // pwm_out is registered against the counter value it will accompany, so the
    // width chosen at the wrap is already in force on the count==0 cycle.
    always_comb begin
        pwm_cnt_next = (pwm_cnt == PERIOD_LAST) ? 32'd0 : pwm_cnt + 32'd1;
        width_calc   = PULSE_MIN + ({24'd0, cur_angle} * DEG_CYC);
        width_next   = (pwm_cnt_next == 32'd0) ? width_calc : width_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= 32'd0;
            width_q <= 32'd0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt_next;
            width_q <= width_next;
            pwm_out <= (pwm_cnt_next < width_next);
        end
    end

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] tmr;
    logic [9:0]    dist_q, dist_val;
    logic          dist_load;
    logic          push;
    logic          step;
    logic          dir_down, dir_next;
    logic [7:0]    angle_next;
    logic [8:0]    up_sum;

    always_comb begin
        state_next = state;
        meas_start = 1'b0;
        push       = 1'b0;
        step       = 1'b0;
        dist_load  = 1'b0;
        dist_val   = meas_dist;
        case (state)
            IDLE: begin
                if (enable) state_next = SETTLE;
            end
            SETTLE: begin
                if (!enable) state_next = IDLE;
                else if (period_start && (settle_cnt == SETTLE_LAST)) state_next = MEASURE;
            end
            MEASURE: begin
                // A done pulse coincident with the request cannot belong to it.
                meas_start = (tmr == '0);
                if (meas_done && (tmr != '0)) begin
                    dist_load  = 1'b1;
                    state_next = STORE;
                end else if (tmr == TIMEOUT_LAST) begin
                    dist_load  = 1'b1;
                    dist_val   = 10'h3FF;
                    state_next = STORE;
                end
            end
            STORE: begin
                push       = 1'b1;
                state_next = NEXT;
            end
            NEXT: begin
                step       = 1'b1;
                state_next = enable ? SETTLE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        up_sum     = {1'b0, cur_angle} + STEP9;
        angle_next = cur_angle;
        dir_next   = dir_down;
        if (!dir_down) begin
            if (up_sum >= {1'b0, ANGLE_TOP}) begin
                angle_next = ANGLE_TOP;
                dir_next   = 1'b1;
            end else begin
                angle_next = up_sum[7:0];
            end
        end else begin
            if ({1'b0, cur_angle} <= STEP9) begin
                angle_next = 8'd0;
                dir_next   = 1'b0;
            end else begin
                angle_next = cur_angle - STEP9[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            tmr        <= '0;
            dist_q     <= 10'd0;
            cur_angle  <= 8'd0;
            dir_down   <= 1'b0;
        end else begin
            state <= state_next;
            if (state != SETTLE)   settle_cnt <= '0;
            else if (period_start) settle_cnt <= settle_cnt + SW'(1);
            tmr <= (state == MEASURE) ? tmr + TW'(1) : '0;
            if (dist_load) dist_q <= dist_val;
            if (step) begin
                cur_angle <= angle_next;
                dir_down  <= dir_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead sample FIFO
    // ------------------------------------------------------------------
    logic [17:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, do_pop, do_push, drop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign rd_data = empty ? 18'd0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {cur_angle, dist_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_radar_sweep_ctrl.sv
// Directed bench for radar_sweep_ctrl with shortened timing parameters and an
// automatic rangefinder responder that returns distance 123 + 7*n for request n.
module tb_radar_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        meas_done = 1'b0;
    logic [9:0]  meas_dist = 10'd0;
    logic        rd_en = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        meas_start, pwm_out, empty, overflow;
    logic [17:0] rd_data;
    logic [2:0]  count;
    logic [7:0]  cur_angle;

    int checks = 0;
    int errors = 0;
    int ms_count = 0;
    bit resp_on = 1'b1;
    int resp_delay = 10;
    logic [9:0]  resp_d;
    logic [17:0] exp_q[$];

    radar_sweep_ctrl #(
        .PWM_PERIOD_CYC(1000),
        .PULSE_MIN_CYC (50),
        .CYC_PER_DEG   (1),
        .ANGLE_MAX     (180),
        .STEP_DEG      (45),
        .SETTLE_PERIODS(1),
        .TIMEOUT_CYC   (200),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .meas_start(meas_start),
        .meas_done (meas_done),
        .meas_dist (meas_dist),
        .pwm_out   (pwm_out),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .cur_angle (cur_angle)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- expected-value model ----------------
    function automatic logic [17:0] sample(input int angle, input int idx);
        logic [9:0] d;
        d = 10'(123 + 7 * idx);
        return {8'(angle), d};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- rangefinder responder ----------------
    always begin
        @(negedge clk);
        if (reset_n && meas_start) begin
            resp_d = 10'(123 + 7 * ms_count);
            ms_count++;
            if (resp_on) begin
                repeat (resp_delay) @(negedge clk);
                meas_dist = resp_d;
                meas_done = 1'b1;
                @(negedge clk);
                meas_done = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_meas_start(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!meas_start && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!meas_start) check({tag, "_timeout"}, 32'(meas_start), 32'd1);
    endtask

    task automatic wait_not_empty(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (empty && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (empty) check({tag, "_timeout"}, 32'(empty), 32'd0);
    endtask

    task automatic measure_pulse(output int w);
        int n;
        n = 0;
        while (pwm_out && n < 3000) begin @(negedge clk); n++; end
        n = 0;
        while (!pwm_out && n < 3000) begin @(negedge clk); n++; end
        w = 0;
        while (pwm_out && w < 3000) begin @(negedge clk); w++; end
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_meas_start"}, 32'(meas_start), 32'd0);
        check({tag, "_pwm_out"},    32'(pwm_out),    32'd0);
        check({tag, "_cur_angle"},  32'(cur_angle),  32'd0);
        check({tag, "_empty"},      32'(empty),      32'd1);
        check({tag, "_count"},      32'(count),      32'd0);
        check({tag, "_overflow"},   32'(overflow),   32'd0);
        check({tag, "_rd_data"},    32'(rd_data),    32'd0);
    endtask

    // ---------------- main sequence ----------------
    int sweep_ang[10] = '{0, 45, 90, 135, 180, 135, 90, 45, 0, 45};

    initial begin
        int w;
        int n;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        // First sample, PWM width at 0 deg and after the step to 45 deg.
        enable  = 1'b1;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(sample(sweep_ang[i], i));
        measure_pulse(w);
        check("pwm_w0", 32'(w), 32'd50);

        for (int i = 0; i < 10; i++) begin
            wait_not_empty($sformatf("sweep%0d", i));
            check($sformatf("sweep%0d_data", i), 32'(rd_data), 32'(exp_q.pop_front()));
            check($sformatf("sweep%0d_starts", i), 32'(ms_count), 32'(i + 1));
            pop();
            if (i == 0) begin
                check("angle_after0", 32'(cur_angle), 32'd45);
                measure_pulse(w);
                check("pwm_w45", 32'(w), 32'd95);
            end
        end
        check("sweep_angle_end", 32'(cur_angle), 32'd90);
        check("sweep_no_ovf", 32'(overflow), 32'd0);

        // Rangefinder silent: timeout stores 0x3FF.
        resp_on = 1'b0;
        wait_meas_start("to_start");
        n = 0;
        while (empty && n < 400) begin @(negedge clk); n++; end
        check("timeout_latency", 32'(n), 32'd201);
        check("timeout_data", 32'(rd_data), 32'({8'd90, 10'h3FF}));
        pop();

        // Fresh start, no pops: fill, overflow, then simultaneous push/pop while full.
        reset_n = 1'b0;
        @(negedge clk);
        check("rst2_count", 32'(count), 32'd0);
        ms_count = 0;
        resp_on  = 1'b1;
        reset_n  = 1'b1;
        n = 0;
        while (!overflow && n < 8000) begin @(negedge clk); n++; end
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_head", 32'(rd_data), 32'(sample(0, 0)));
        n = 0;
        while (ms_count < 6 && n < 3000) begin @(negedge clk); n++; end
        repeat (14) @(negedge clk);
        check("ovf6_count", 32'(count), 32'd4);
        check("ovf6_sticky", 32'(overflow), 32'd1);
        check("ovf6_head", 32'(rd_data), 32'(sample(0, 0)));
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        wait_meas_start("full_start");
        repeat (11) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("full_pp_count", 32'(count), 32'd4);
        check("full_pp_ovf", 32'(overflow), 32'd0);
        exp_q.push_back(sample(45, 1));
        exp_q.push_back(sample(90, 2));
        exp_q.push_back(sample(135, 3));
        exp_q.push_back(sample(90, 6));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d", i), 32'(rd_data), 32'(exp_q.pop_front()));
            pop();
        end
        check("drain_empty", 32'(empty), 32'd1);
        pop();
        check("pop_empty_count", 32'(count), 32'd0);
        check("pop_empty_data", 32'(rd_data), 32'd0);

        // enable dropped mid-measurement: sample completes, angle steps, then idle.
        wait_meas_start("en_start");
        enable = 1'b0;
        repeat (20) @(negedge clk);
        check("en_count", 32'(count), 32'd1);
        check("en_data", 32'(rd_data), 32'(sample(45, 7)));
        check("en_angle", 32'(cur_angle), 32'd0);
        repeat (2500) @(negedge clk);
        check("en_no_start", 32'(ms_count), 32'd8);
        measure_pulse(w);
        check("en_pwm_w", 32'(w), 32'd50);

        // Asynchronous reset during a measurement; the late done must be ignored.
        enable = 1'b1;
        wait_meas_start("ar_start0");
        n = 0;
        while (count != 3'd2 && n < 100) begin @(negedge clk); n++; end
        check("ar_count2", 32'(count), 32'd2);
        resp_delay = 50;
        wait_meas_start("ar_start1");
        check("ar_angle", 32'(cur_angle), 32'd45);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        check_reset_outputs("arst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        check("late_done_empty", 32'(empty), 32'd1);
        check("late_done_count", 32'(count), 32'd0);
        check("late_done_starts", 32'(ms_count), 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
